// File: rtl/gs_mixer_mac_pkg.sv
// Shared types and width helpers for the General Sound output mixer.
// Widths are derived from the mixer parameters so every file agrees on them.
package gs_mixer_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed sample times zero-extended volume.
    function automatic int prod_width(input int in_w, input int vol_w);
        return in_w + vol_w + 1;
    endfunction

    // Product width plus growth for summing every channel, plus one guard bit.
    function automatic int acc_width(input int in_w, input int vol_w, input int channels);
        return in_w + vol_w + 1 + $clog2(channels) + 1;
    endfunction

    function automatic int idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/gs_mixer_mac_sat_shift.sv
// Combinational scale-and-saturate stage: applies the output gain shift to one
// accumulator and clamps it to the signed OUT_W range.
module gs_sat_shift #(
    parameter int ACC_W = 18,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] res,
    output logic                    clip
);

    // The shifted value must be at least OUT_W bits wide for the range limits below.
    localparam int SH_W = ACC_W + SHIFT;

    localparam logic signed [SH_W-1:0] MAX_V = {{(SH_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SH_W-1:0] MIN_V = {{(SH_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SH_W-1:0] sh_s;

    // Shift, then clamp to the signed output range.
    always_comb begin
        sh_s = SH_W'(acc) <<< SHIFT;
        res  = sh_s[OUT_W-1:0];
        clip = 1'b0;
        if (sh_s > MAX_V) begin
            res  = {1'b0, {(OUT_W-1){1'b1}}};
            clip = 1'b1;
        end else if (sh_s < MIN_V) begin
            res  = {1'b1, {(OUT_W-1){1'b0}}};
            clip = 1'b1;
        end else begin
            res  = sh_s[OUT_W-1:0];
            clip = 1'b0;
        end
    end

endmodule

// File: rtl/gs_mixer_mac.sv
// General Sound output mixer: per-channel volume and L/R routing through one
// time-multiplexed multiplier, followed by shift/saturation of each side.
module gs_mixer_mac
    import gs_mixer_mac_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 8,
    parameter int VOL_W    = 6,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 1
) (
    input  logic                      clk_sys,
    input  logic                      areset_n,
    input  logic                      ce,
    input  logic                      smp_stb,
    input  logic [CHANNELS*IN_W-1:0]  ch_data,
    input  logic [CHANNELS*VOL_W-1:0] ch_vol,
    input  logic [CHANNELS*2-1:0]     ch_route,
    input  logic                      clr_flags,
    output logic [OUT_W-1:0]          out_l,
    output logic [OUT_W-1:0]          out_r,
    output logic                      out_stb,
    output logic                      busy,
    output logic                      clip_l,
    output logic                      clip_r,
    output logic                      drop
);

    localparam int PROD_W = prod_width(IN_W, VOL_W);
    localparam int ACC_W  = acc_width(IN_W, VOL_W, CHANNELS);
    localparam int IDX_W  = idx_width(CHANNELS);

    state_t state_r, state_nxt;

    logic [IN_W-1:0]  data_r  [CHANNELS];
    logic [VOL_W-1:0] vol_r   [CHANNELS];
    logic [1:0]       route_r [CHANNELS];
    logic [IDX_W-1:0] idx_r;

    logic signed [ACC_W-1:0] acc_l_r, acc_r_r;
    logic signed [OUT_W-1:0] sat_l_s, sat_r_s;
    logic                    clip_l_s, clip_r_s;

    logic accept_s, mac_s, done_s, drop_set_s;

    logic signed [IN_W-1:0]   smp_s;
    logic signed [VOL_W:0]    vol_s;
    logic signed [PROD_W-1:0] prod_s;
    logic [1:0]               route_s;

    // State register.
    always_ff @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next state and per-cycle strobes; DONE never accepts a new sample set.
    always_comb begin
        state_nxt  = state_r;
        accept_s   = 1'b0;
        mac_s      = 1'b0;
        done_s     = 1'b0;
        drop_set_s = ce & smp_stb & busy;
        case (state_r)
            ST_IDLE: begin
                if (ce && smp_stb) begin
                    accept_s  = 1'b1;
                    state_nxt = ST_MAC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (ce) begin
                    mac_s = 1'b1;
                    if (idx_r == IDX_W'(CHANNELS-1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_MAC;
                    end
                end else begin
                    state_nxt = ST_MAC;
                end
            end
            ST_DONE: begin
                if (ce) begin
                    done_s    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Offset-binary sample to signed, times unsigned volume.
    always_comb begin
        smp_s   = $signed({~data_r[idx_r][IN_W-1], data_r[idx_r][IN_W-2:0]});
        vol_s   = $signed({1'b0, vol_r[idx_r]});
        prod_s  = PROD_W'(smp_s) * PROD_W'(vol_s);
        route_s = route_r[idx_r];
    end

    gs_sat_shift #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_l (
        .acc  (acc_l_r),
        .res  (sat_l_s),
        .clip (clip_l_s)
    );

    gs_sat_shift #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_r (
        .acc  (acc_r_r),
        .res  (sat_r_s),
        .clip (clip_r_s)
    );

    // Snapshot, channel index, accumulators and result registers.
    always_ff @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n) begin
            for (int n = 0; n < CHANNELS; n++) begin
                data_r[n]  <= '0;
                vol_r[n]   <= '0;
                route_r[n] <= 2'b00;
            end
            idx_r   <= '0;
            acc_l_r <= '0;
            acc_r_r <= '0;
            out_l   <= '0;
            out_r   <= '0;
            out_stb <= 1'b0;
            busy    <= 1'b0;
        end else begin
            out_stb <= 1'b0;
            if (accept_s) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    data_r[n]  <= ch_data[n*IN_W +: IN_W];
                    vol_r[n]   <= ch_vol[n*VOL_W +: VOL_W];
                    route_r[n] <= ch_route[n*2 +: 2];
                end
                idx_r   <= '0;
                acc_l_r <= '0;
                acc_r_r <= '0;
                busy    <= 1'b1;
            end
            if (mac_s) begin
                if (route_s[0]) acc_l_r <= acc_l_r + ACC_W'(prod_s);
                if (route_s[1]) acc_r_r <= acc_r_r + ACC_W'(prod_s);
                idx_r <= idx_r + IDX_W'(1);
            end
            if (done_s) begin
                out_l   <= sat_l_s;
                out_r   <= sat_r_s;
                out_stb <= 1'b1;
                busy    <= 1'b0;
                idx_r   <= '0;
                acc_l_r <= '0;
                acc_r_r <= '0;
            end
        end
    end

    // Sticky flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n) begin
            clip_l <= 1'b0;
            clip_r <= 1'b0;
            drop   <= 1'b0;
        end else begin
            if (done_s && clip_l_s) clip_l <= 1'b1;
            else if (clr_flags)     clip_l <= 1'b0;
            else                    clip_l <= clip_l;
            if (done_s && clip_r_s) clip_r <= 1'b1;
            else if (clr_flags)     clip_r <= 1'b0;
            else                    clip_r <= clip_r;
            if (drop_set_s)         drop   <= 1'b1;
            else if (clr_flags)     drop   <= 1'b0;
            else                    drop   <= drop;
        end
    end

endmodule
